// File: rtl/display_pkg.sv
// Shared types and constants for the score display: FSM states, segment codes,
// and the double-dabble adjust step.
package display_pkg;

    localparam int SCORE_W = 18;
    localparam int DIGITS  = 6;
    localparam int BCD_W   = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } state_e;

    // Active-low, bit order gfedcba.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Add 3 to every nibble >= 5; a nibble never exceeds 9 here, so no carry out.
    function automatic logic [BCD_W-1:0] dd_add3(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_decoder.sv
// One BCD nibble plus blank flag to an active-low seven-segment pattern.
module hex_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (nibble_i)
                4'd0:    seg_o = SEG_DIGIT[0];
                4'd1:    seg_o = SEG_DIGIT[1];
                4'd2:    seg_o = SEG_DIGIT[2];
                4'd3:    seg_o = SEG_DIGIT[3];
                4'd4:    seg_o = SEG_DIGIT[4];
                4'd5:    seg_o = SEG_DIGIT[5];
                4'd6:    seg_o = SEG_DIGIT[6];
                4'd7:    seg_o = SEG_DIGIT[7];
                4'd8:    seg_o = SEG_DIGIT[8];
                4'd9:    seg_o = SEG_DIGIT[9];
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display.sv
// Samples one score on a refresh tick or request, converts it with an iterative
// double-dabble engine and latches six blanked segment patterns.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | waiting for refresh tick or force_update
//   ST_LOAD  | capture selected score, clear BCD and iteration counter
//   ST_SHIFT | one add-3 / shift-left step per cycle, 18 steps
//   ST_LATCH | register the decoded digits onto HEX0..5, pulse done
module score_display
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 500000,
    parameter bit BLANK_LEADING  = 1'b1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [SCORE_W-1:0]  currentScore,
    input  logic [SCORE_W-1:0]  highScore,
    input  logic                show_high,
    input  logic                force_update,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic                busy,
    output logic                done
);

    localparam int               CNT_W      = $clog2(REFRESH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [4:0]       ITER_LAST  = 5'(SCORE_W - 1);
    localparam logic [6:0]       HEX_RST_HI = BLANK_LEADING ? SEG_BLANK : SEG_DIGIT[0];

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tick;
    state_e             state_q;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
    logic [4:0]         iter_q;
    logic               busy_q, done_q;
    logic [6:0]         hex_q [DIGITS];
    logic [6:0]         seg_w [DIGITS];
    logic [DIGITS-1:0]  blank_w;
    logic               hi_zero;

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bcd_adj        = dd_add3(bcd_q);
    assign {bcd_d, bin_d} = {bcd_adj[BCD_W-2:0], bin_q, 1'b0};

    // A digit blanks only when it and every more-significant digit are zero.
    always_comb begin
        hi_zero = 1'b1;
        blank_w = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            hi_zero    = hi_zero && (bcd_q[4*k +: 4] == 4'd0);
            blank_w[k] = BLANK_LEADING && hi_zero;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dec
        hex_decoder u_dec (
            .nibble_i (bcd_q[4*k +: 4]),
            .blank_i  (blank_w[k]),
            .seg_o    (seg_w[k])
        );
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            bin_q    <= '0;
            bcd_q    <= '0;
            iter_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hex_q[0] <= SEG_DIGIT[0];
            for (int k = 1; k < DIGITS; k++) hex_q[k] <= HEX_RST_HI;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick || force_update) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    bin_q   <= show_high ? highScore : currentScore;
                    bcd_q   <= '0;
                    iter_q  <= '0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    bin_q  <= bin_d;
                    bcd_q  <= bcd_d;
                    iter_q <= iter_q + 5'd1;
                    if (iter_q == ITER_LAST) state_q <= ST_LATCH;
                end
                ST_LATCH: begin
                    for (int k = 0; k < DIGITS; k++) hex_q[k] <= seg_w[k];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_score_display.sv
// Randomized bench for score_display: three instances (forced-only with and
// without blanking, plus a fast-refresh one) checked against a decimal model.
module tb_score_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] cur_score, hi_score;
    logic        show_high, force_upd;
    logic [6:0]  hf [6];
    logic [6:0]  hz [6];
    logic [6:0]  hr [6];
    logic        busy_f, done_f, busy_z, done_z, busy_r, done_r;

    int n_checks = 0;
    int n_pass   = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #10 clk = ~clk;

    score_display #(.REFRESH_CYCLES(1000000), .BLANK_LEADING(1'b1)) dut_f (
        .CLOCK_50(clk), .reset(rst_n), .currentScore(cur_score), .highScore(hi_score),
        .show_high(show_high), .force_update(force_upd),
        .HEX0(hf[0]), .HEX1(hf[1]), .HEX2(hf[2]), .HEX3(hf[3]), .HEX4(hf[4]), .HEX5(hf[5]),
        .busy(busy_f), .done(done_f));

    score_display #(.REFRESH_CYCLES(1000000), .BLANK_LEADING(1'b0)) dut_z (
        .CLOCK_50(clk), .reset(rst_n), .currentScore(cur_score), .highScore(hi_score),
        .show_high(show_high), .force_update(force_upd),
        .HEX0(hz[0]), .HEX1(hz[1]), .HEX2(hz[2]), .HEX3(hz[3]), .HEX4(hz[4]), .HEX5(hz[5]),
        .busy(busy_z), .done(done_z));

    score_display #(.REFRESH_CYCLES(50), .BLANK_LEADING(1'b1)) dut_r (
        .CLOCK_50(clk), .reset(rst_n), .currentScore(cur_score), .highScore(hi_score),
        .show_high(show_high), .force_update(1'b0),
        .HEX0(hr[0]), .HEX1(hr[1]), .HEX2(hr[2]), .HEX3(hr[3]), .HEX4(hr[4]), .HEX5(hr[5]),
        .busy(busy_r), .done(done_r));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected pattern for decimal digit k of v, straight from the display rules.
    function automatic logic [6:0] ref_seg(input int unsigned v, input int k, input bit bl);
        int unsigned p;
        int unsigned d;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        d = (v / p) % 10;
        if (bl && k > 0 && v < p) return 7'h7F;
        return seg_tab[d];
    endfunction

    task automatic check_hex(input string tag, input int unsigned v);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s_f_hex%0d", tag, k), 32'(hf[k]), 32'(ref_seg(v, k, 1'b1)));
            check($sformatf("%s_z_hex%0d", tag, k), 32'(hz[k]), 32'(ref_seg(v, k, 1'b0)));
        end
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s_f_hex%0d", tag, k), 32'(hf[k]), (k == 0) ? 32'h40 : 32'h7F);
            check($sformatf("%s_z_hex%0d", tag, k), 32'(hz[k]), 32'h40);
        end
        check({tag, "_busy"}, 32'(busy_f), 32'd0);
        check({tag, "_done"}, 32'(done_f), 32'd0);
    endtask

    task automatic force_conv(input string tag, input int unsigned cur, input int unsigned hi,
                              input bit sel);
        int lat;
        int unsigned v;
        @(negedge clk);
        cur_score = 18'(cur);
        hi_score  = 18'(hi);
        show_high = sel;
        force_upd = 1'b1;
        @(negedge clk);
        force_upd = 1'b0;
        check({tag, "_busy"}, 32'(busy_f), 32'd1);
        lat = 0;
        while (!done_f && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd20);
        check({tag, "_done_z"}, 32'(done_z), 32'd1);
        v = sel ? hi : cur;
        check_hex(tag, v);
        @(negedge clk);
        check({tag, "_done_width"}, 32'(done_f), 32'd0);
        check({tag, "_busy_end"}, 32'(busy_f), 32'd0);
    endtask

    initial begin
        int unsigned v, other, lim, r_val;
        int          nd, ndone, gap;
        bit          sel;

        rst_n = 1'b0;
        cur_score = '0; hi_score = '0; show_high = 1'b0; force_upd = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst_low");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("rst_rel");

        force_conv("c123456", 123456, 5, 1'b0);
        force_conv("cmax", 77, 262143, 1'b1);
        force_conv("c7", 7, 0, 1'b0);
        force_conv("c0", 0, 9, 1'b0);

        for (int it = 0; it < 16; it++) begin
            nd  = int'($urandom_range(1, 6));
            lim = 1;
            for (int i = 0; i < nd; i++) lim = lim * 10;
            lim = (lim - 1 > 262143) ? 262143 : lim - 1;
            v     = $urandom_range(0, lim);
            other = $urandom_range(0, 262143);
            sel   = 1'($urandom_range(0, 1));
            if (sel) force_conv($sformatf("rnd%0d", it), other, v, 1'b1);
            else     force_conv($sformatf("rnd%0d", it), v, other, 1'b0);
        end

        // Re-request and input change mid-conversion must not disturb it.
        @(negedge clk);
        cur_score = 18'd98765; show_high = 1'b0; force_upd = 1'b1;
        @(negedge clk);
        force_upd = 1'b0;
        repeat (5) @(negedge clk);
        force_upd = 1'b1; cur_score = 18'd4321;
        @(negedge clk);
        force_upd = 1'b0;
        ndone = 0;
        for (int c = 0; c < 45; c++) begin
            if (done_f) begin
                if (ndone == 0) check_hex("busy_ign", 98765);
                ndone++;
            end
            @(negedge clk);
        end
        check("busy_ign_ndone", 32'(ndone), 32'd1);

        // Reset during SHIFT aborts and restores reset outputs.
        @(negedge clk);
        cur_score = 18'd250000; force_upd = 1'b1;
        @(negedge clk);
        force_upd = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_mid_busy_pre", 32'(busy_f), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid_async");
        repeat (3) @(negedge clk);
        check_reset("rst_mid_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset("rst_mid_rel");
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_f) ndone++;
        end
        check("rst_mid_no_done", 32'(ndone), 32'd0);

        // Periodic refresh on the fast instance.
        @(negedge clk);
        rst_n = 1'b0;
        cur_score = 18'd31415; show_high = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gap = 0;
        while (!done_r && gap < 120) begin
            @(negedge clk);
            gap++;
        end
        check("refr_first", 32'(done_r), 32'd1);
        for (int k = 0; k < 6; k++)
            check($sformatf("refr0_hex%0d", k), 32'(hr[k]), 32'(ref_seg(31415, k, 1'b1)));
        for (int n = 1; n <= 3; n++) begin
            r_val = $urandom_range(0, 262143);
            cur_score = 18'(r_val);
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!done_r && gap < 120);
            check($sformatf("refr%0d_period", n), 32'(gap), 32'd50);
            for (int k = 0; k < 6; k++)
                check($sformatf("refr%0d_hex%0d", n, k), 32'(hr[k]), 32'(ref_seg(r_val, k, 1'b1)));
        end
        check("refr_f_idle", 32'(busy_f), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Sequential binary-to-decimal converter and seven-segment driver that consumes the 18-bit `currentScore` / `highScore` values produced by the ball/scoring stage. It sits directly downstream of that stage and drives the six board HEX displays. On a periodic refresh tick, or on request, it samples one score, converts it with an iterative double-dabble (shift-add-3) engine, then latches six segment patterns with leading-zero blanking.

## Interface

Parameters:
- `REFRESH_CYCLES`, default 500000: clock cycles between automatic conversions (10 ms at 50 MHz). Must be ≥ 21.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros, 0 shows all six digits.

Ports:
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `currentScore`  in  18  live score from the ball stage.
- `highScore`  in  18  best score from the ball stage.
- `show_high`  in  1  source select, sampled in LOAD: 1 selects highScore, 0 selects currentScore.
- `force_update`  in  1  single-cycle request to start a conversion immediately.
- `HEX0`..`HEX5`  out  7 each  segment patterns, active-low, bit order gfedcba; HEX0 is the least-significant digit.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse in the cycle the HEX outputs update.

## Operation

- Refresh counter: counts 0..REFRESH_CYCLES-1 and wraps. It raises an internal tick when count = REFRESH_CYCLES-1. It runs in every state.
- FSM states:
  - IDLE: on (tick | force_update), go to LOAD. The request is ignored in any other state, with no queueing.
  - LOAD: sample the selected score into an 18-bit shift register. Clear the 24-bit BCD register. Clear the iteration counter. Go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {BCD, bin} left one bit. After 18 iterations (counter 17), go to LATCH.
  - LATCH: encode the six nibbles and register them onto HEX0..5. Pulse `done`. Go to IDLE.
- `busy` is 1 in LOAD, SHIFT and LATCH.
- Value range:
  - Maximum input is 262143, which needs 6 digits, so no overflow is possible.
  - The BCD register is exactly 24 bits.
  - The add-3 step never carries between nibbles.
- Leading-zero blanking (BLANK_LEADING = 1):
  - Digit k is blanked (7'h7F) if it and all more-significant digits are 0.
  - HEX0 is never blanked, so the value 0 shows "0".
- Segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Codes for nibbles 10–15 are unreachable and output 7'h7F.
- Input changes during a conversion have no effect until the next LOAD.

## Timing

- Reset values: FSM = IDLE, refresh counter = 0, shift and BCD registers = 0, `busy` = 0, `done` = 0.
  - With BLANK_LEADING = 1: HEX0 = 7'h40, HEX1..5 = 7'h7F.
  - With BLANK_LEADING = 0: all six HEX = 7'h40.
- Reset mid-conversion aborts it immediately; all outputs return to their reset values.
- Latency: if `force_update` is sampled high at edge N, then:
  - LOAD occupies cycle N+1.
  - SHIFT occupies cycles N+2..N+19.
  - LATCH is at N+20; HEX outputs and `done` are valid after edge N+20.
  - This is 20 cycles in total.
- HEX outputs are registered and hold between conversions; they never glitch.
- A tick and `force_update` in the same IDLE cycle start a single conversion.

## Structure

- Shared package `display_pkg`:
  - FSM state encoding (IDLE, LOAD, SHIFT, LATCH).
  - Segment constants SEG_BLANK = 7'h7F and SEG_DIGIT[0..9].
  - Localparams SCORE_W = 18 and DIGITS = 6.
- Sub-module `hex_decoder`: combinational 4-bit nibble plus blank flag to 7-bit active-low pattern. Instantiated six times in LATCH-path logic.
- The top level holds the refresh counter, FSM, double-dabble datapath and output registers.

## Test plan

- Reset: assert `reset` = 0 mid-simulation, including once during SHIFT. Required: HEX0 = 40, HEX1..5 = 7F, `busy` = 0, `done` = 0 while reset is low and after release.
- Conversion: currentScore = 123456, show_high = 0, one-cycle `force_update`. Required: `done` exactly 20 cycles later, with HEX5..HEX0 = 79, 24, 30, 19, 12, 02.
- Maximum value: highScore = 262143, show_high = 1, force. Required: HEX5..0 = 24, 02, 24, 79, 19, 30.
- Blanking: score 7 with BLANK_LEADING = 1 gives HEX0 = 78, HEX1..5 = 7F; score 0 gives HEX0 = 40.
- Busy handling: pulse `force_update` again during SHIFT and change currentScore mid-conversion. Required: one `done` only, showing the LOAD-time value.
- Refresh: REFRESH_CYCLES = 50 with no force. Required: `done` pulses exactly every 50 cycles, and HEX tracks a changed score at the next refresh.
